// File: rtl/ram_out_reader.sv
// ram_out_reader: streams a finished output image from the output-pixel BRAM
// in raster order onto a valid/ready pixel stream.
// Ports:
//   clk, rst_n        - single clock, asynchronous active-low reset
//   start             - one-cycle pulse that begins a frame (ignored while busy)
//   busy, done        - frame in progress / one-cycle completion pulse
//   rd_addr, rd_data  - RAM read port (1-cycle registered read latency)
//   m_valid, m_ready  - downstream stream handshake
//   m_data, m_last    - pixel value and end-of-frame marker
module ram_out_reader #(
    parameter int unsigned W               = 64,
    parameter int unsigned H               = 64,
    parameter int unsigned TOTAL_PIXEL     = W * H,
    parameter int unsigned TOTAL_PIXEL_BIT = (W * H > 1) ? $clog2(W * H) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [TOTAL_PIXEL_BIT-1:0] rd_addr,
    input  logic [7:0]                 rd_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [7:0]                 m_data,
    output logic                       m_last
);

    // Counter one bit wider than the address so a power-of-two frame terminates.
    localparam int unsigned              CW        = TOTAL_PIXEL_BIT + 1;
    localparam logic [CW-1:0]            LAST_IDX  = CW'(TOTAL_PIXEL - 1);
    localparam logic [TOTAL_PIXEL_BIT-1:0] LAST_ADDR = TOTAL_PIXEL_BIT'(TOTAL_PIXEL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;

    logic [TOTAL_PIXEL_BIT-1:0] r_rd_addr;
    logic [CW-1:0]              r_issued;
    logic                       r_inflight;
    logic                       r_inflight_last;
    logic                       r_busy;
    logic                       r_done;

    // Two-entry prefetch FIFO held as head/tail registers; head drives the stream.
    logic [1:0]                 r_count;
    logic                       r_m_valid;
    logic [7:0]                 r_head_data;
    logic                       r_head_last;
    logic [7:0]                 r_tail_data;
    logic                       r_tail_last;

    logic                       w_accept;
    logic                       w_issue;
    logic                       w_issue_last;
    logic                       w_pop;
    logic                       w_push;
    logic                       w_final_pop;
    logic [2:0]                 w_occ;
    logic [1:0]                 w_count_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and read-issue decisions
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_issue_last = 1'b0;
        w_final_pop  = 1'b0;
        w_pop        = r_m_valid & m_ready;
        w_push       = r_inflight;
        // Slots already committed: stored entries plus the read still in the RAM pipe.
        w_occ        = {1'b0, r_count} + {2'b00, r_inflight};
        w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

        case (r_state)
            S_IDLE: begin
                // The done cycle still counts as busy, so a start there is dropped.
                if (start && !r_done) begin
                    w_accept     = 1'b1;
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                if (w_occ < (3'd2 + {2'b00, w_pop})) begin
                    w_issue = 1'b1;
                    if (r_issued == LAST_IDX) begin
                        w_issue_last = 1'b1;
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && r_head_last) begin
                    w_final_pop  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Address sequencing, in-flight tracking and frame status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr       <= '0;
            r_issued        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rd_addr <= '0;
                r_issued  <= '0;
            end else if (w_issue) begin
                r_issued <= r_issued + CW'(1);
                // Saturate so the address never wraps back into the frame.
                if (r_rd_addr != LAST_ADDR) begin
                    r_rd_addr <= r_rd_addr + TOTAL_PIXEL_BIT'(1);
                end
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
            r_done          <= w_final_pop;
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Prefetch FIFO: head only changes on pop or when filling an empty FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= 2'd0;
            r_m_valid   <= 1'b0;
            r_head_data <= 8'd0;
            r_head_last <= 1'b0;
            r_tail_data <= 8'd0;
            r_tail_last <= 1'b0;
        end else begin
            assert (!(w_push && !w_pop && (r_count == 2'd2)))
                else $error("ram_out_reader: push into full prefetch FIFO");
            r_count   <= w_count_next;
            r_m_valid <= (w_count_next != 2'd0);
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head_data <= rd_data;
                        r_head_last <= r_inflight_last;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head_data <= rd_data;
                        r_head_last <= r_inflight_last;
                    end else if (w_push) begin
                        r_tail_data <= rd_data;
                        r_tail_last <= r_inflight_last;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                        if (w_push) begin
                            r_tail_data <= rd_data;
                            r_tail_last <= r_inflight_last;
                        end
                    end
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_addr = r_rd_addr;
    assign m_valid = r_m_valid;
    assign m_data  = r_head_data;
    assign m_last  = r_head_last;

endmodule

// File: tb/tb_ram_out_reader.sv
// Bench for ram_out_reader: a 4x4 instance and a 1x1 instance, each with a
// registered-read RAM model. Expected pixels come from the RAM array contents
// in address order; timing expectations come from the frame-level rules.
module tb_ram_out_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       start4, busy4, done4, m_valid4, m_ready4, m_last4;
    logic [3:0] rd_addr4;
    logic [7:0] rd_data4, m_data4;
    logic [7:0] mem4 [16];

    logic       start1, busy1, done1, m_valid1, m_ready1, m_last1;
    logic [0:0] rd_addr1;
    logic [7:0] rd_data1, m_data1;
    logic [7:0] mem1 [2];

    int n_pass  = 0;
    int n_total = 0;

    ram_out_reader #(.W(4), .H(4)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start4),
        .busy    (busy4),
        .done    (done4),
        .rd_addr (rd_addr4),
        .rd_data (rd_data4),
        .m_valid (m_valid4),
        .m_ready (m_ready4),
        .m_data  (m_data4),
        .m_last  (m_last4)
    );

    ram_out_reader #(.W(1), .H(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start1),
        .busy    (busy1),
        .done    (done1),
        .rd_addr (rd_addr1),
        .rd_data (rd_data1),
        .m_valid (m_valid1),
        .m_ready (m_ready1),
        .m_data  (m_data1),
        .m_last  (m_last1)
    );

    // Registered-read RAMs
    always @(posedge clk) rd_data4 <= mem4[rd_addr4];
    always @(posedge clk) rd_data1 <= mem1[rd_addr1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 4x4 frame. mode 0: ready always 1; 1: random ready; 2: ready low
    // for stall_n cycles after start. inj_start: cycle for a stray start pulse.
    // abort_after: return once this many beats are received (-1: run to done).
    task automatic run4(input int mode, input int stall_n, input int inj_start,
                        input int abort_after, input bit start_on_done);
        int         beat        = 0;
        int         cyc         = 0;
        int         first_valid = -1;
        int         last_hs     = -1;
        bit         held        = 1'b0;
        bit         fin         = 1'b0;
        logic [7:0] hd          = 8'd0;
        logic       hl          = 1'b0;
        start4 = 1'b1;
        while (!fin && cyc < 200) begin
            if (cyc > 0) start4 = (cyc == inj_start);
            case (mode)
                0:       m_ready4 = 1'b1;
                1:       m_ready4 = 1'($urandom_range(0, 1));
                default: m_ready4 = (cyc > stall_n);
            endcase
            if (cyc == 1) check("busy_after_start", 32'(busy4), 32'd1);
            if (held) begin
                check("stall_hold_valid", 32'(m_valid4), 32'd1);
                check("stall_hold_data", 32'(m_data4), 32'(hd));
                check("stall_hold_last", 32'(m_last4), 32'(hl));
            end
            held = 1'b0;
            if (m_valid4 && first_valid < 0) begin
                first_valid = cyc;
                if (mode == 0) check("first_valid_cycle", 32'(cyc), 32'd3);
            end
            if (mode == 2 && cyc >= 1 && cyc <= stall_n) begin
                check("stall_rd_addr_le2", 32'(rd_addr4 <= 4'd2), 32'd1);
                if (cyc >= 3) begin
                    check("stall_valid", 32'(m_valid4), 32'd1);
                    check("stall_data", 32'(m_data4), 32'(mem4[0]));
                end
            end
            if (mode != 1 && m_ready4 && beat > 0 && beat < 16)
                check("gapless", 32'(m_valid4), 32'd1);
            if (m_valid4 && m_ready4) begin
                check("beat_data", 32'(m_data4), 32'(mem4[beat[3:0]]));
                check("beat_last", 32'(m_last4), 32'(beat == 15));
                beat++;
                last_hs = cyc;
            end else if (m_valid4) begin
                held = 1'b1;
                hd   = m_data4;
                hl   = m_last4;
            end
            if (done4) begin
                check("done_cycle", 32'(cyc), 32'(last_hs + 1));
                check("done_beat_count", 32'(beat), 32'd16);
                check("busy_in_done", 32'(busy4), 32'd1);
                start4 = start_on_done;
                step();
                start4 = 1'b0;
                check("busy_after_done", 32'(busy4), 32'd0);
                check("done_one_cycle", 32'(done4), 32'd0);
                check("idle_no_valid", 32'(m_valid4), 32'd0);
                fin = 1'b1;
            end else if (abort_after >= 0 && beat == abort_after) begin
                fin = 1'b1;
            end else begin
                step();
                cyc++;
            end
        end
        if (!fin) check("frame_timeout", 32'd0, 32'd1);
        start4   = 1'b0;
        m_ready4 = 1'b0;
    endtask

    initial begin
        int beats1;
        int hs1;
        bit fin1;
        for (int i = 0; i < 16; i++) mem4[i] = 8'(i) ^ 8'hA5;
        mem1[0] = 8'h3C;
        mem1[1] = 8'h00;
        rst_n    = 1'b0;
        start4   = 1'b0;
        m_ready4 = 1'b0;
        start1   = 1'b0;
        m_ready1 = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_rd_addr", 32'(rd_addr4), 32'd0);
        check("rst_valid", 32'(m_valid4), 32'd0);
        check("rst_data", 32'(m_data4), 32'd0);
        check("rst_last", 32'(m_last4), 32'd0);
        check("rst_valid_1x1", 32'(m_valid1), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();
        check("idle_after_rst", 32'(busy4), 32'd0);

        // Back-to-back frames: the second starts the cycle after done
        run4(0, 0, -1, -1, 1'b0);
        run4(0, 0, -1, -1, 1'b0);

        // Random backpressure, stray start mid-frame and in the done cycle
        run4(1, 0, 6, -1, 1'b1);
        step();
        check("done_cycle_start_ignored", 32'(busy4), 32'd0);

        // Long stall right after start, then release
        run4(2, 10, -1, -1, 1'b0);
        run4(1, 0, -1, -1, 1'b0);

        // Asynchronous reset after beat 7
        run4(0, 0, -1, 8, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy4), 32'd0);
        check("arst_done", 32'(done4), 32'd0);
        check("arst_rd_addr", 32'(rd_addr4), 32'd0);
        check("arst_valid", 32'(m_valid4), 32'd0);
        check("arst_data", 32'(m_data4), 32'd0);
        check("arst_last", 32'(m_last4), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            m_ready4 = 1'b1;
            step();
            check("post_rst_idle_busy", 32'(busy4), 32'd0);
            check("post_rst_idle_valid", 32'(m_valid4), 32'd0);
        end
        m_ready4 = 1'b0;
        run4(0, 0, -1, -1, 1'b0);

        // Random image contents with random backpressure
        for (int i = 0; i < 16; i++) mem4[i] = 8'($urandom);
        run4(1, 0, -1, -1, 1'b0);
        run4(2, 4, -1, -1, 1'b0);

        // Single-pixel frame
        beats1   = 0;
        hs1      = -1;
        fin1     = 1'b0;
        start1   = 1'b1;
        m_ready1 = 1'b1;
        for (int c = 0; c < 40 && !fin1; c++) begin
            if (c > 0) start1 = 1'b0;
            if (m_valid1 && m_ready1) begin
                if (beats1 == 0) check("one_first_valid", 32'(c), 32'd3);
                check("one_data", 32'(m_data1), 32'h3C);
                check("one_last", 32'(m_last1), 32'd1);
                beats1++;
                hs1 = c;
            end
            if (done1) begin
                check("one_done_cycle", 32'(c), 32'(hs1 + 1));
                check("one_beat_count", 32'(beats1), 32'd1);
                fin1 = 1'b1;
            end
            step();
        end
        if (!fin1) check("one_timeout", 32'd0, 32'd1);
        check("one_busy_after", 32'(busy1), 32'd0);
        m_ready1 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
